// File: rtl/arkanoid_pkg.sv
// Shared constants and types for the ball motion block.
package arkanoid_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int RADIUS   = 8;
  localparam int SPEED    = 2;
  localparam int PADDLE_Y = 440;
  localparam int PADDLE_W = 64;
  localparam int START_X  = 320;
  localparam int START_Y  = 400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_BRICK  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // dxn/dyn: 1 = moving towards smaller coordinates
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               dxn;
    logic               dyn;
  } ball_t;

endpackage

// File: rtl/ball_step.sv
// One-frame step of a single ball: move, bounce off walls, catch on the paddle.
module ball_step
  import arkanoid_pkg::*;
(
  input  ball_t              ball_i,
  input  logic [COORD_W-1:0] paddle_x_i,
  output ball_t              ball_o,
  output logic               lost_o
);

  localparam logic signed [10:0] R_S    = 11'(RADIUS);
  localparam logic signed [10:0] SP_S   = 11'(SPEED);
  localparam logic signed [10:0] XMAX_S = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] YMAX_S = 11'(SCREEN_H - 1);
  localparam logic signed [10:0] PY_S   = 11'(PADDLE_Y);
  localparam logic [11:0]        PW_U   = 12'(PADDLE_W);
  localparam logic [11:0]        PH_U   = 12'(PADDLE_W / 2);

  logic signed [10:0] x_s, y_s, nx, ny;
  logic [11:0]        nx_u, px_lo;

  // Candidate position, walls first, then the paddle (range compare kept unsigned 12b so it cannot wrap)
  always_comb begin
    ball_o = ball_i;
    lost_o = 1'b0;
    x_s    = $signed({1'b0, ball_i.x});
    y_s    = $signed({1'b0, ball_i.y});
    nx     = ball_i.dxn ? x_s - SP_S : x_s + SP_S;
    ny     = ball_i.dyn ? y_s - SP_S : y_s + SP_S;
    if (nx - R_S < 11'sd0) begin
      nx         = R_S;
      ball_o.dxn = 1'b0;
    end
    if (nx + R_S > XMAX_S) begin
      nx         = XMAX_S - R_S;
      ball_o.dxn = 1'b1;
    end
    if (ny - R_S < 11'sd0) begin
      ny         = R_S;
      ball_o.dyn = 1'b0;
    end
    if (ny - R_S > YMAX_S) begin
      lost_o = 1'b1;
    end
    nx_u  = {1'b0, nx};
    px_lo = {2'b00, paddle_x_i};
    if (!ball_i.dyn && (y_s + R_S < PY_S) && (ny + R_S >= PY_S) &&
        (nx_u >= px_lo) && (nx_u < px_lo + PW_U)) begin
      ny         = PY_S - R_S - 11'sd1;
      ball_o.dyn = 1'b1;
      ball_o.dxn = (nx_u < px_lo + PH_U);
    end
    ball_o.x = nx[COORD_W-1:0];
    ball_o.y = ny[COORD_W-1:0];
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball update for up to two balls with brick queries and atomic commit.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for frame_tick
//  ST_STEP   | step ball idx into its shadow slot
//  ST_BRICK  | hold brick query for ball idx until ack, apply reflections
//  ST_NEXT   | advance to ball 1, or go commit after ball 1
//  ST_COMMIT | copy shadows to outputs, then pending launch, then pending split
module ball_motion
  import arkanoid_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               frame_tick_i,
  input  logic               launch_i,
  input  logic               split_i,
  input  logic [COORD_W-1:0] paddle_x_i,
  output logic               brk_req_o,
  output logic [COORD_W-1:0] brk_x_o,
  output logic [COORD_W-1:0] brk_y_o,
  input  logic               brk_ack_i,
  input  logic               brk_hit_x_i,
  input  logic               brk_hit_y_i,
  output logic [COORD_W-1:0] x1_o,
  output logic [COORD_W-1:0] y1_o,
  output logic [COORD_W-1:0] x2_o,
  output logic [COORD_W-1:0] y2_o,
  output logic [1:0]         active_o,
  output logic [5:0]         radius_o,
  output logic [1:0]         lost_o,
  output logic               busy_o
);

  state_e     state_q, state_d;
  logic       idx_q, idx_d;
  ball_t      ball_q [2];
  ball_t      ball_d [2];
  ball_t      sh_q   [2];
  ball_t      sh_d   [2];
  logic [1:0] act_q, act_d;
  logic [1:0] sh_act_q, sh_act_d;
  logic [1:0] lost_q, lost_d;
  logic       launch_pend_q, launch_pend_d;
  logic       split_pend_q, split_pend_d;
  logic [1:0] act_c;
  ball_t      step_ball;
  logic       step_lost;

  ball_step u_step (
    .ball_i     (ball_q[idx_q]),
    .paddle_x_i (paddle_x_i),
    .ball_o     (step_ball),
    .lost_o     (step_lost)
  );

  // Frame sequencer: next state, shadow updates and commit
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ball_d        = ball_q;
    sh_d          = sh_q;
    act_d         = act_q;
    sh_act_d      = sh_act_q;
    lost_d        = lost_q;
    launch_pend_d = launch_pend_q | launch_i;
    split_pend_d  = split_pend_q | split_i;
    act_c         = sh_act_q;
    brk_req_o     = 1'b0;
    lost_o        = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick_i) begin
          state_d  = ST_STEP;
          idx_d    = 1'b0;
          sh_act_d = act_q;
          lost_d   = 2'b00;
        end
      end
      ST_STEP: begin
        if (act_q[idx_q]) begin
          sh_d[idx_q] = step_ball;
          if (step_lost) begin
            sh_act_d[idx_q] = 1'b0;
            lost_d[idx_q]   = 1'b1;
            state_d         = ST_NEXT;
          end else begin
            state_d = ST_BRICK;
          end
        end else begin
          sh_d[idx_q] = ball_q[idx_q];
          state_d     = ST_NEXT;
        end
      end
      ST_BRICK: begin
        brk_req_o = 1'b1;
        if (brk_ack_i) begin
          if (brk_hit_x_i) begin
            sh_d[idx_q].x   = ball_q[idx_q].x;
            sh_d[idx_q].dxn = ~sh_q[idx_q].dxn;
          end
          if (brk_hit_y_i) begin
            sh_d[idx_q].y   = ball_q[idx_q].y;
            sh_d[idx_q].dyn = ~sh_q[idx_q].dyn;
          end
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (!idx_q) begin
          idx_d   = 1'b1;
          state_d = ST_STEP;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        lost_o    = lost_q;
        ball_d[0] = sh_q[0];
        ball_d[1] = sh_q[1];
        if (launch_pend_d && (act_c == 2'b00)) begin
          ball_d[0].x   = COORD_W'(START_X);
          ball_d[0].y   = COORD_W'(START_Y);
          ball_d[0].dxn = 1'b0;
          ball_d[0].dyn = 1'b1;
          act_c[0]      = 1'b1;
        end
        if (split_pend_d && (act_c == 2'b01)) begin
          ball_d[1].x   = ball_d[0].x;
          ball_d[1].y   = ball_d[0].y;
          ball_d[1].dxn = ~ball_d[0].dxn;
          ball_d[1].dyn = ball_d[0].dyn;
          act_c[1]      = 1'b1;
        end
        act_d         = act_c;
        launch_pend_d = 1'b0;
        split_pend_d  = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, committed and shadow registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      idx_q         <= 1'b0;
      ball_q[0]     <= '0;
      ball_q[1]     <= '0;
      sh_q[0]       <= '0;
      sh_q[1]       <= '0;
      act_q         <= 2'b00;
      sh_act_q      <= 2'b00;
      lost_q        <= 2'b00;
      launch_pend_q <= 1'b0;
      split_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ball_q        <= ball_d;
      sh_q          <= sh_d;
      act_q         <= act_d;
      sh_act_q      <= sh_act_d;
      lost_q        <= lost_d;
      launch_pend_q <= launch_pend_d;
      split_pend_q  <= split_pend_d;
    end
  end

  assign brk_x_o  = sh_q[idx_q].x;
  assign brk_y_o  = sh_q[idx_q].y;
  assign x1_o     = ball_q[0].x;
  assign y1_o     = ball_q[0].y;
  assign x2_o     = ball_q[1].x;
  assign y2_o     = ball_q[1].y;
  assign active_o = act_q;
  assign radius_o = 6'(RADIUS);
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: hand table of early frames, reset/pending corner cases,
// then long randomised play checked against a frame-level reference model.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, launch = 1'b0, split = 1'b0;
  logic [9:0] paddle_x = 10'd0;
  logic       brk_req, brk_ack = 1'b0, hit_x = 1'b0, hit_y = 1'b0;
  logic [9:0] brk_x, brk_y, x1, y1, x2, y2;
  logic [1:0] active, lost;
  logic [5:0] radius;
  logic       busy;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick), .launch_i(launch),
    .split_i(split), .paddle_x_i(paddle_x), .brk_req_o(brk_req), .brk_x_o(brk_x),
    .brk_y_o(brk_y), .brk_ack_i(brk_ack), .brk_hit_x_i(hit_x), .brk_hit_y_i(hit_y),
    .x1_o(x1), .y1_o(y1), .x2_o(x2), .y2_o(y2), .active_o(active),
    .radius_o(radius), .lost_o(lost), .busy_o(busy)
  );

  int total = 0, bad = 0;

  // reference model state
  int       mx[2], my[2];
  bit       mdxn[2], mdyn[2];
  bit [1:0] mact;
  int cov_l = 0, cov_r = 0, cov_t = 0, cov_p = 0, cov_lost = 0, cov_split = 0;

  typedef struct {
    int act, x1, y1, x2, y2, lost, nq, qx0, qy0, qx1, qy1;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit launch, split, hx, hy;
    int dly, pad;
    int e_act, e_x1, e_y1, e_x2, e_y2;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mdxn[i] = 1'b0; mdyn[i] = 1'b0;
    end
    mact = 2'b00;
    sb.delete();
  endtask

  // One frame of the reference: step, walls, paddle, brick hits, then commit
  task automatic model_frame(input bit l, input bit s, input bit hx, input bit hy, input int pad);
    exp_t     e;
    bit [1:0] nact;
    int       nq;
    e = '{default: 0};
    nact = mact;
    nq = 0;
    for (int i = 0; i < 2; i++) begin
      if (mact[i]) begin
        int nx, ny;
        bit dx, dy;
        dx = mdxn[i];
        dy = mdyn[i];
        nx = mdxn[i] ? mx[i] - 2 : mx[i] + 2;
        ny = mdyn[i] ? my[i] - 2 : my[i] + 2;
        if (nx < 8)   begin nx = 8;   dx = 1'b0; cov_l++; end
        if (nx > 631) begin nx = 631; dx = 1'b1; cov_r++; end
        if (ny < 8)   begin ny = 8;   dy = 1'b0; cov_t++; end
        if (ny > 487) begin
          nact[i] = 1'b0;
          e.lost |= (1 << i);
          cov_lost++;
        end else begin
          if (!mdyn[i] && my[i] < 432 && ny >= 432 && nx >= pad && nx < pad + 64) begin
            ny = 431;
            dy = 1'b1;
            dx = (nx < pad + 32);
            cov_p++;
          end
          if (nq == 0) begin e.qx0 = nx; e.qy0 = ny; end
          else         begin e.qx1 = nx; e.qy1 = ny; end
          nq++;
          if (hx) begin nx = mx[i]; dx = ~dx; end
          if (hy) begin ny = my[i]; dy = ~dy; end
        end
        mx[i] = nx; my[i] = ny; mdxn[i] = dx; mdyn[i] = dy;
      end
    end
    mact = nact;
    if (l && mact == 2'b00) begin
      mx[0] = 320; my[0] = 400; mdxn[0] = 1'b0; mdyn[0] = 1'b1; mact[0] = 1'b1;
    end
    if (s && mact == 2'b01) begin
      mx[1] = mx[0]; my[1] = my[0]; mdxn[1] = ~mdxn[0]; mdyn[1] = mdyn[0]; mact[1] = 1'b1;
      cov_split++;
    end
    e.act = int'(mact);
    e.x1 = mx[0]; e.y1 = my[0]; e.x2 = mx[1]; e.y2 = my[1];
    e.nq = nq;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0; launch = 1'b0; split = 1'b0; brk_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one frame; lat>0 pulses launch mid-frame, tick_again re-pulses frame_tick while busy
  task automatic run_frame(input bit l, input bit s, input bit hx, input bit hy,
                           input int dly, input int pad, input int lat, input bit tick_again);
    exp_t e;
    int   qi = 0, reqcnt = 0, reqtot = 0, lostacc = 0, lostcyc = 0;
    bit   done = 1'b0;
    model_frame(l, s, hx, hy, pad);
    e = sb[0];
    @(negedge clk);
    paddle_x = 10'(pad);
    frame_tick = 1'b1;
    launch = l && (lat == 0);
    split = s;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      brk_ack = 1'b0; hit_x = 1'b0; hit_y = 1'b0;
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (lost != 2'b00) begin
          lostacc |= int'(lost);
          lostcyc++;
        end
        if (brk_req) begin
          reqcnt++;
          reqtot++;
          if (reqcnt == 1) begin
            check("brk_x", int'(brk_x), (qi == 0) ? e.qx0 : e.qx1);
            check("brk_y", int'(brk_y), (qi == 0) ? e.qy0 : e.qy1);
          end
          if (reqcnt >= dly) begin
            brk_ack = 1'b1; hit_x = hx; hit_y = hy;
            reqcnt = 0;
            qi++;
          end
        end
      end
      frame_tick = tick_again && (c == 0);
      launch = l && (lat == c + 1) && !done;
      split = 1'b0;
    end
    frame_tick = 1'b0; launch = 1'b0;
    void'(sb.pop_front());
    if (!done) begin
      total++; bad++;
      $display("FAIL frame_timeout: busy still high after 400 cycles, expected commit");
      apply_reset();
    end else begin
      check("active", int'(active), e.act);
      check("lost", lostacc, e.lost);
      check("lost_cycles", lostcyc, (e.lost != 0) ? 1 : 0);
      check("queries", qi, e.nq);
      check("req_cycles", reqtot, e.nq * dly);
      if (e.act[0]) begin check("x1", int'(x1), e.x1); check("y1", int'(y1), e.y1); end
      if (e.act[1]) begin check("x2", int'(x2), e.x2); check("y2", int'(y2), e.y2); end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_x1"}, int'(x1), 0);
    check({tag, "_y1"}, int'(y1), 0);
    check({tag, "_x2"}, int'(x2), 0);
    check({tag, "_y2"}, int'(y2), 0);
    check({tag, "_lost"}, int'(lost), 0);
    check({tag, "_brk_req"}, int'(brk_req), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    //          launch split hx hy dly pad act  x1   y1   x2   y2
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1, 320, 400,   0,   0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 322, 398,   0,   0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 1, 324, 398,   0,   0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1, 326, 400,   0,   0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 326, 402,   0,   0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 3, 324, 404, 324, 404};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 3, 322, 406, 326, 406};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 3, 322, 406, 326, 406};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3, 324, 404, 324, 404};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 3, 326, 402, 322, 402};

    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("radius", int'(radius), 8);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      run_frame(tbl[k].launch, tbl[k].split, tbl[k].hx, tbl[k].hy, tbl[k].dly, tbl[k].pad, 0, 1'b0);
      check($sformatf("tbl%0d_active", k), int'(active), tbl[k].e_act);
      check($sformatf("tbl%0d_x1", k), int'(x1), tbl[k].e_x1);
      check($sformatf("tbl%0d_y1", k), int'(y1), tbl[k].e_y1);
      if (tbl[k].e_act >= 2) begin
        check($sformatf("tbl%0d_x2", k), int'(x2), tbl[k].e_x2);
        check($sformatf("tbl%0d_y2", k), int'(y2), tbl[k].e_y2);
      end
    end

    // reset while a brick query is outstanding, with a launch pending
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (!brk_req && n < 10) begin @(negedge clk); n++; end
    check("brick_reached", int'(brk_req), 1);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    repeat (2) @(negedge clk);
    check("req_held_no_ack", int'(brk_req), 1);
    check("busy_in_brick", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0);

    // launch pulsed mid-frame plus a stray frame_tick while busy
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 2, 1'b1);
    check("midlaunch_x1", int'(x1), 320);
    check("midlaunch_y1", int'(y1), 400);
    @(negedge clk);
    check("tick_ignored_busy", int'(busy), 0);

    for (int f = 0; f < 2500; f++) begin
      bit l, s, hx, hy;
      int d, pad;
      l  = (mact == 2'b00) && ($urandom_range(3) == 0);
      s  = ($urandom_range(31) == 0);
      hx = ($urandom_range(127) == 0);
      hy = ($urandom_range(127) == 0);
      d  = $urandom_range(3, 1);
      if ($urandom_range(1) == 0) begin
        pad = mx[0] - $urandom_range(63);
        if (pad < 0) pad = 0;
      end else begin
        pad = $urandom_range(1023);
      end
      run_frame(l, s, hx, hy, d, pad, 0, 1'b0);
    end

    check("seen_left_wall", int'(cov_l > 0), 1);
    check("seen_right_wall", int'(cov_r > 0), 1);
    check("seen_top_wall", int'(cov_t > 0), 1);
    check("seen_paddle", int'(cov_p > 0), 1);
    check("seen_lost", int'(cov_lost > 0), 1);
    check("seen_split", int'(cov_split > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
